// File: rtl/fpu_result_buffer.sv
// Result FIFO between the FPU core and user I/O. Words leave either over a
// 4-phase strobe/ack pad handshake (STREAM) or through Wishbone reads (WB).
module fpu_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid_i,
  input  logic [WIDTH-1:0]           res_data_i,
  output logic                       res_ready_o,
  input  logic                       mode_i,
  output logic [WIDTH-1:0]           io_data_o,
  output logic                       io_strb_o,
  input  logic                       io_ack_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [3:0]                 wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  output logic                       wb_ack_o,
  output logic [31:0]                wb_dat_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b001,
    S_PRESENT  = 3'b010,
    S_WAIT_LOW = 3'b100
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  io_data_q;
  logic              io_strb_q;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic              ready_q, ready_d;
  logic              ack_s1_q, ack_s2_q;

  logic              full, empty, push, pop, st_pop, wb_pop;
  logic              wb_req, wb_rd, wb_wr, wb_mode;
  logic [WIDTH-1:0]  head;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:1]};

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // A pop in this cycle does not make room for this cycle's push.
  assign push    = res_valid_i & ~full;
  assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_q;
  assign wb_rd   = wb_req & ~wb_we_i;
  assign wb_wr   = wb_req & wb_we_i;
  assign wb_mode = mode_i & (state_q == S_IDLE);
  assign wb_pop  = wb_rd & (wb_adr_i[3:2] == 2'd0) & wb_mode & ~empty;
  assign st_pop  = (state_q == S_PRESENT) & ack_s2_q;
  assign pop     = wb_pop | st_pop;

  always_comb begin
    rdata = '0;
    case (wb_adr_i[3:2])
      2'd0: rdata = (wb_mode & ~empty) ? 32'(head) : '0;
      2'd1: rdata = {20'd0, ovf_q, full, empty, 9'(count_q)};
      2'd2: rdata = 32'(last_q);
      default: rdata = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ready_d  = (count_d != CW'(DEPTH));
    last_d   = pop ? head : last_q;
    // Overflow set takes priority over a same-cycle software clear.
    ovf_d    = (ovf_q & ~(wb_wr & (wb_adr_i[3:2] == 2'd1) & wb_dat_i[0]))
             | (res_valid_i & full);
    wb_ack_d = wb_req;
    wb_dat_d = wb_rd ? rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      wb_ack_q <= 1'b0;
      wb_dat_q <= '0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      wb_ack_q <= wb_ack_d;
      wb_dat_q <= wb_dat_d;
      ack_s1_q <= io_ack_i;
      ack_s2_q <= ack_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      io_data_q <= '0;
      io_strb_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (~empty & ~mode_i) begin
          state_q   <= S_PRESENT;
          io_data_q <= head;
          io_strb_q <= 1'b1;
        end
        S_PRESENT: if (ack_s2_q) begin
          state_q   <= S_WAIT_LOW;
          io_strb_q <= 1'b0;
        end
        S_WAIT_LOW: if (~ack_s2_q) state_q <= S_IDLE;
        default: begin
          state_q   <= S_IDLE;
          io_strb_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_ready_o = ready_q;
  assign io_data_o   = io_data_q;
  assign io_strb_o   = io_strb_q;
  assign wb_ack_o    = wb_ack_q;
  assign wb_dat_o    = wb_dat_q;
  assign count_o     = count_q;
endmodule

// File: tb/tb_fpu_result_buffer.sv
// Bench for fpu_result_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fpu_result_buffer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic              clk = 0;
  logic              rst = 1;
  logic              res_valid = 0;
  logic [WIDTH-1:0]  res_data = '0;
  logic              res_ready;
  logic              mode = 0;
  logic [WIDTH-1:0]  io_data;
  logic              io_strb;
  logic              io_ack = 0;
  logic              wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [3:0]        wb_adr = '0;
  logic [31:0]       wb_dat = '0;
  logic              wb_ack;
  logic [31:0]       wb_rdat;
  logic [3:0]        count;

  fpu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
    .mode_i(mode), .io_data_o(io_data), .io_strb_o(io_strb), .io_ack_i(io_ack),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
    .wb_dat_i(wb_dat), .wb_ack_o(wb_ack), .wb_dat_o(wb_rdat), .count_o(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf, m_strb, m_ack, m_ready;
  logic [WIDTH-1:0] m_last, m_io, m_head;
  logic [31:0]      m_dat, m_rd;
  int               m_phase;   // 0 idle, 1 word on pads, 2 waiting for ack low
  bit [1:0]         m_sync;
  int               m_n;
  bit               m_full, m_empty, m_acc, m_wbm, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_strb = 0; m_ack = 0; m_ready = 0;
      m_last = '0; m_io = '0; m_dat = '0; m_phase = 0; m_sync = '0;
    end else begin
      m_n     = mq.size();
      m_full  = (m_n == DEPTH);
      m_empty = (m_n == 0);
      m_head  = m_empty ? '0 : mq[0];
      m_acc   = wb_cyc && wb_stb && !m_ack;
      m_wbm   = mode && (m_phase == 0);
      m_pop   = 0;
      m_rd    = '0;
      if (m_acc && !wb_we) begin
        case (wb_adr[3:2])
          2'd0: if (m_wbm && !m_empty) begin m_rd = 32'(m_head); m_pop = 1; end
          2'd1: m_rd = {20'd0, m_ovf, m_full, m_empty, 9'(m_n)};
          2'd2: m_rd = 32'(m_last);
          default: m_rd = '0;
        endcase
      end
      case (m_phase)
        0: if (!m_empty && !mode) begin m_phase = 1; m_io = m_head; m_strb = 1; end
        1: if (m_sync[1]) begin m_pop = 1; m_strb = 0; m_phase = 2; end
        default: if (!m_sync[1]) m_phase = 0;
      endcase
      if (m_pop) m_last = mq.pop_front();
      if (m_acc && wb_we && wb_adr[3:2] == 2'd1 && wb_dat[0]) m_ovf = 0;
      if (res_valid) begin
        if (m_full) m_ovf = 1;
        else mq.push_back(res_data);
      end
      m_sync  = {m_sync[0], io_ack};
      m_ack   = m_acc;
      m_dat   = (m_acc && !wb_we) ? m_rd : '0;
      m_ready = (mq.size() != DEPTH);
    end
  end

  // Per-cycle compare, plus capture of each newly presented pad word.
  logic [WIDTH-1:0] seen[$];
  bit prev_strb = 0;
  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin
      chk("res_ready", res_ready, m_ready);
      chk("count", count, mq.size());
      chk("io_strb", io_strb, m_strb);
      chk("io_data", io_data, m_io);
      chk("wb_ack", wb_ack, m_ack);
      chk("wb_dat", wb_rdat, m_dat);
    end
    if (io_strb && !prev_strb) seen.push_back(io_data);
    prev_strb = io_strb;
  end

  // Pad-side responder with random latency.
  bit auto_ack = 0, ack_hold = 0;
  initial forever begin
    @(negedge clk);
    if (ack_hold) io_ack = 1;
    else if (!auto_ack) io_ack = 0;
    else if (!io_ack && io_strb && $urandom_range(1, 0) == 1) io_ack = 1;
    else if (io_ack && !io_strb && $urandom_range(1, 0) == 1) io_ack = 0;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_word(logic [WIDTH-1:0] d);
    res_valid = 1; res_data = d;
    @(negedge clk);
    res_valid = 0;
  endtask

  task automatic wb_xfer(bit we, logic [3:0] adr, logic [31:0] dat, output logic [31:0] rd);
    int t = 0;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat = dat;
    do begin @(negedge clk); t++; end while (!wb_ack && t < 10);
    if (!wb_ack) chk("wb_ack_timeout", 32'(wb_ack), 1);
    rd = wb_rdat;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    @(negedge clk);
    chk("wb_ack_single_cycle", 32'(wb_ack), 0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((count != 0 || io_strb || io_ack) && t < 300) begin @(negedge clk); t++; end
    chk("drain_in_time", 32'(t < 300), 1);
  endtask

  logic [31:0] rd;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_strb", io_strb, 0);
    chk("rst_ready", res_ready, 0);
    chk("rst_wb_ack", wb_ack, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", res_ready, 1);

    // 1: stream three words over the pads
    mode = 0; auto_ack = 1;
    push_word(16'h3F80); push_word(16'h4000); push_word(16'h4040);
    chk("t1_count3", count, 3);
    wait_drain();
    chk("t1_nwords", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("t1_w0", seen[0], 16'h3F80);
      chk("t1_w1", seen[1], 16'h4000);
      chk("t1_w2", seen[2], 16'h4040);
    end
    wb_xfer(0, 4'h8, 0, rd);
    chk("t1_last", rd, 32'h4040);

    // 2: overfill with no drain
    auto_ack = 0; mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH + 2; i++) push_word(16'h0100 + 16'(i));
    chk("t2_ready", res_ready, 0);
    chk("t2_count", count, DEPTH);
    wb_xfer(0, 4'h4, 0, rd);
    chk("t2_status", rd, 32'h0C08);

    // 3: clear ovf
    wb_xfer(1, 4'h4, 32'h1, rd);
    wb_xfer(0, 4'h4, 0, rd);
    chk("t3_status", rd, 32'h0408);

    // 4: drain through DATA, then the single-word case
    for (int i = 0; i < DEPTH; i++) begin
      wb_xfer(0, 4'h0, 0, rd);
      chk("t4_drain", rd, 32'h0100 + i);
    end
    push_word(16'hC2F6);
    wb_xfer(0, 4'h0, 0, rd);
    chk("t4_read1", rd, 32'h0000C2F6);
    wb_xfer(0, 4'h0, 0, rd);
    chk("t4_read2", rd, 0);
    wb_xfer(0, 4'h4, 0, rd);
    chk("t4_status_empty", rd, 32'h0200);

    // 5: push and pop together at occupancy 3, across pointer wraps
    for (int i = 0; i < 3; i++) push_word(16'h0500 + 16'(i));
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin
      res_valid = 1; res_data = 16'h0503 + 16'(i);
      wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 4'h0;
      @(negedge clk);
      res_valid = 0;
      wb_cyc = 0; wb_stb = 0;
      chk("t5_ack", wb_ack, 1);
      chk("t5_data", wb_rdat, 32'h0500 + i);
      chk("t5_count", count, 3);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) wb_xfer(0, 4'h0, 0, rd);
    chk("t5_empty", count, 0);

    // 6: reset in the middle of a handshake
    mode = 0; auto_ack = 0;
    push_word(16'h7777);
    begin
      int t = 0;
      while (!io_strb && t < 20) begin @(negedge clk); t++; end
      chk("t6_strb_seen", io_strb, 1);
    end
    rst = 1; #1;
    chk("t6_strb_async", io_strb, 0);
    chk("t6_count_async", count, 0);
    ack_hold = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    chk("t6_count_held_ack", count, 0);
    wb_xfer(0, 4'h8, 0, rd);
    chk("t6_last_clear", rd, 0);
    ack_hold = 0;
    repeat (4) @(negedge clk);

    // 7: random traffic against the model
    auto_ack = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        rst = 1; wb_cyc = 0; wb_stb = 0; res_valid = 0;
        @(negedge clk);
        rst = 0;
      end
      res_valid = ($urandom_range(2, 0) == 0);
      res_data  = WIDTH'($urandom);
      if ($urandom_range(49, 0) == 0) mode = ~mode;
      if (wb_cyc && wb_ack) begin
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
      end else if (!wb_cyc && $urandom_range(3, 0) == 0) begin
        wb_cyc = 1; wb_stb = 1;
        wb_we  = ($urandom_range(3, 0) == 0);
        wb_adr = 4'($urandom);
        wb_dat = $urandom;
      end
    end
    wb_cyc = 0; wb_stb = 0; res_valid = 0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
